// File: rtl/bram_stream_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bram_rd_pkg
//  Purpose  : Shared types and helpers for the BRAM-to-stream reader.
//             Holds the control FSM state encoding, the mode encodings and
//             an elaboration-time clog2 helper for the byte-lane shift.
//  Revision : 1.0 - initial release
// ============================================================================
package bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_LOOP    = 1'b1;

  // Ceiling log2; bounded loop so it stays usable at elaboration time.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_stream_rd_if.sv
`default_nettype none
// ============================================================================
//  Module   : bram_stream_rd_if
//  Purpose  : Valid/ready output stream carrying read data and an
//             end-of-pass marker.
//  Ports    : m_data  - stream data word
//             m_valid - data valid
//             m_ready - sink ready
//             m_last  - last word of a pass through the window
//  Revision : 1.0 - initial release
// ============================================================================
interface bram_stream_rd_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface
`default_nettype wire

// File: rtl/bram_stream_rd_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with register-based storage; the head entry
//             is presented directly from the storage registers, so output
//             data stays stable while it is not being read.
//  Ports    : clk, rst_n   - clock, asynchronous active-low reset
//             wr_en_i/wr_data_i - push (caller guarantees space)
//             rd_en_i      - pop head (ignored when empty)
//             rd_data_o    - head entry
//             empty_o      - no entries
//             count_o      - number of stored entries
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
  import bram_rd_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [clog2(DEPTH):0]    count_o
);
  localparam int PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_rd;

  assign do_rd     = rd_en_i && (count_q != '0);
  assign rd_data_o = mem_q[rptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wptr_q] <= wr_data_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (do_rd) rptr_q <= rptr_q + PTR_W'(1);
      case ({wr_en_i, do_rd})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/bram_stream_rd.sv
`default_nettype none
// ============================================================================
//  Module   : bram_stream_rd
//  Purpose  : Reads a programmed window of a block RAM through its native
//             port at a programmable pace and streams the words out with
//             valid/ready backpressure. One-shot or continuous-loop modes.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             start, stop         - control pulses
//             mode, start_addr, rd_len, rd_freq - transfer setup
//             ram_*               - native BRAM port (read only)
//             strm                - output stream (master)
//             busy, done          - status
//  Revision : 1.0 - initial release
// ============================================================================
module bram_stream_rd
  import bram_rd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [31:0]           rd_len,
  input  logic [31:0]           rd_freq,
  output logic                  ram_clk,
  output logic                  ram_en,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [DATA_W-1:0]     ram_wr_data,
  output logic                  ram_rst,
  input  logic [DATA_W-1:0]     ram_rd_data,
  bram_stream_rd_if.master      strm,
  output logic                  busy,
  output logic                  done
);
  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = clog2(BYTES);
  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, addr_q, addr_d;
  logic               mode_q;
  logic [31:0]        nwords_q, freq_q, pace_q, pace_d, wcnt_q, wcnt_d;
  logic               done_q, done_d;
  // In-flight pipe: one valid/last bit per outstanding BRAM read.
  logic [RD_LAT-1:0]  pv_q, pl_q;

  logic [31:0]        start_nwords;
  logic [CNT_W-1:0]   inflight, occupancy;
  logic [PTR_W:0]     fifo_cnt;
  logic               fifo_empty, pop, credits_ok, issue, issue_last;
  logic [DATA_W:0]    fifo_rd;

  assign start_nwords = rd_len >> SHIFT;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(pv_q[i]);
  end

  // Credits: reserve a FIFO slot for every read that is already outstanding,
  // so the buffer can never overflow regardless of backpressure.
  assign occupancy  = CNT_W'(fifo_cnt) + inflight;
  assign credits_ok = occupancy < CNT_W'(FIFO_DEPTH);
  assign issue      = (state_q == RUN) && !stop && (pace_q == '0) && credits_ok;
  assign issue_last = issue && (wcnt_q == nwords_q - 32'd1);

  assign pop = !fifo_empty && strm.m_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    pace_d  = (pace_q != '0) ? pace_q - 32'd1 : pace_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_nwords == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            addr_d  = start_addr;
            wcnt_d  = '0;
            pace_d  = '0;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (issue) begin
          pace_d = freq_q - 32'd1;
          if (issue_last) begin
            addr_d = base_q;
            wcnt_d = '0;
            if (mode_q == MODE_ONESHOT) state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_STEP;
            wcnt_d = wcnt_q + 32'd1;
          end
        end
      end
      DRAIN: begin
        // Leave on the cycle of the final pop so done lands one cycle later.
        if (inflight == '0 &&
            (fifo_empty || (fifo_cnt == (PTR_W+1)'(1) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      base_q   <= '0;
      mode_q   <= MODE_ONESHOT;
      nwords_q <= '0;
      freq_q   <= 32'd1;
      pace_q   <= '0;
      wcnt_q   <= '0;
      done_q   <= 1'b0;
      pv_q     <= '0;
      pl_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pace_q  <= pace_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      if (state_q == IDLE && start) begin
        base_q   <= start_addr;
        mode_q   <= mode;
        nwords_q <= start_nwords;
        freq_q   <= (rd_freq == '0) ? 32'd1 : rd_freq;
      end
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
      pv_q[0] <= issue;
      pl_q[0] <= issue_last;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (pv_q[RD_LAT-1]),
    .wr_data_i ({pl_q[RD_LAT-1], ram_rd_data}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign strm.m_valid = !fifo_empty;
  assign strm.m_data  = fifo_rd[DATA_W-1:0];
  assign strm.m_last  = fifo_rd[DATA_W] && !fifo_empty;

  assign ram_clk     = clk;
  assign ram_en      = issue;
  assign ram_addr    = addr_q;
  assign ram_we      = '0;
  assign ram_wr_data = '0;
  assign ram_rst     = 1'b0;

  assign busy = (state_q != IDLE);
  assign done = done_q;
endmodule
`default_nettype wire

// File: tb/tb_bram_stream_rd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_stream_rd
//  Purpose  : Directed self-checking bench for bram_stream_rd (RD_LAT=2,
//             FIFO_DEPTH=4, 32-bit data) with a two-stage BRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_stream_rd;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [31:0] start_addr = '0, rd_len = '0, rd_freq = '0;
  logic        ram_clk, ram_en, ram_rst, busy, done;
  logic [31:0] ram_addr, ram_wr_data;
  logic [3:0]  ram_we;
  logic [31:0] ram_rd_data = '0, bram_d1 = '0;

  int total = 0, bad = 0, cyc = 0, t0 = 0;

  int          en_cyc[$];
  logic [31:0] en_addr[$];
  logic [31:0] out_data[$];
  logic        out_last[$];
  int          out_cyc[$];
  int          done_cyc[$];
  logic        done_busy[$];

  bram_stream_rd_if #(.DATA_W(DATA_W)) strm_if ();

  bram_stream_rd #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .start_addr(start_addr), .rd_len(rd_len), .rd_freq(rd_freq),
    .ram_clk(ram_clk), .ram_en(ram_en), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wr_data(ram_wr_data), .ram_rst(ram_rst), .ram_rd_data(ram_rd_data),
    .strm(strm_if.master), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bram_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Two-cycle read latency BRAM model.
  always @(posedge clk) begin
    if (ram_en) bram_d1 <= bram_word(ram_addr);
    ram_rd_data <= bram_d1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en) begin
        en_cyc.push_back(cyc);
        en_addr.push_back(ram_addr);
      end
      if (strm_if.m_valid && strm_if.m_ready) begin
        out_data.push_back(strm_if.m_data);
        out_last.push_back(strm_if.m_last);
        out_cyc.push_back(cyc);
      end
      if (done) begin
        done_cyc.push_back(cyc);
        done_busy.push_back(busy);
      end
    end
  end

  task automatic clear_logs();
    en_cyc.delete(); en_addr.delete(); out_data.delete(); out_last.delete();
    out_cyc.delete(); done_cyc.delete(); done_busy.delete();
  endtask

  // Returns at #1 into the cycle right after the edge that sampled start.
  task automatic do_start(input logic [31:0] a, input logic [31:0] l,
                          input logic [31:0] f, input logic md, input logic stp);
    @(posedge clk); #1;
    clear_logs();
    start_addr = a; rd_len = l; rd_freq = f; mode = md;
    start = 1'b1; stop = stp;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_cyc.size() == 0; i++) @(posedge clk);
    total++;
    if (done_cyc.size() == 0) begin
      bad++; $display("FAIL done_timeout got=no_done want=done within %0d cycles", limit);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL rst_ram_en got=%b want=0", ram_en); end
    total++; if (ram_addr !== 32'h0) begin bad++; $display("FAIL rst_ram_addr got=%h want=0", ram_addr); end
    total++; if (strm_if.m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b want=0", strm_if.m_valid); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_status got=busy%b done%b want=00", busy, done); end
    total++; if (ram_we !== 4'h0 || ram_wr_data !== 32'h0 || ram_rst !== 1'b0) begin
      bad++; $display("FAIL rst_tieoff got=%h/%h/%b want=0/0/0", ram_we, ram_wr_data, ram_rst);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    total++; if (busy !== 1'b0 || ram_en !== 1'b0) begin bad++; $display("FAIL idle_after_rst got=busy%b en%b want=00", busy, ram_en); end
  endtask

  task automatic test_oneshot();
    do_start(32'h100, 32'd16, 32'd1, 1'b0, 1'b0);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL oneshot_busy_c1 got=%b want=1", busy); end
    wait_done(100);
    total++; if (en_cyc.size() != 4) begin bad++; $display("FAIL oneshot_issues got=%0d want=4", en_cyc.size()); end
    for (int i = 0; i < en_cyc.size() && i < 4; i++) begin
      total++;
      if (en_addr[i] !== 32'h100 + 32'(4*i) || en_cyc[i] != t0 + i) begin
        bad++; $display("FAIL oneshot_issue%0d got=%h@%0d want=%h@%0d", i, en_addr[i], en_cyc[i], 32'h100 + 32'(4*i), t0 + i);
      end
    end
    total++; if (out_data.size() != 4) begin bad++; $display("FAIL oneshot_words got=%0d want=4", out_data.size()); end
    for (int i = 0; i < out_data.size() && i < 4; i++) begin
      total++;
      if (out_data[i] !== bram_word(32'h100 + 32'(4*i)) || out_last[i] !== (i == 3)) begin
        bad++; $display("FAIL oneshot_word%0d got=%h/%b want=%h/%b", i, out_data[i], out_last[i], bram_word(32'h100 + 32'(4*i)), i == 3);
      end
    end
    total++; if (out_cyc.size() > 0 && out_cyc[0] != t0 + 3) begin bad++; $display("FAIL oneshot_first_valid got=%0d want=%0d", out_cyc[0], t0 + 3); end
    total++; if (done_cyc.size() != 1 || done_cyc[0] != t0 + 7 || done_busy[0] !== 1'b0) begin
      bad++; $display("FAIL oneshot_done got=n%0d@%0d want=n1@%0d busy0", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t0 + 7);
    end
  endtask

  task automatic test_pacing();
    do_start(32'h200, 32'd12, 32'd5, 1'b0, 1'b0);
    wait_done(200);
    total++; if (en_cyc.size() != 3) begin bad++; $display("FAIL pace_issues got=%0d want=3", en_cyc.size()); end
    for (int i = 0; i < en_cyc.size() && i < 3; i++) begin
      total++;
      if (en_cyc[i] != t0 + 5*i || en_addr[i] !== 32'h200 + 32'(4*i)) begin
        bad++; $display("FAIL pace_issue%0d got=%h@%0d want=%h@%0d", i, en_addr[i], en_cyc[i], 32'h200 + 32'(4*i), t0 + 5*i);
      end
    end
    total++; if (out_data.size() != 3 || out_last[2] !== 1'b1 || out_data[2] !== bram_word(32'h208)) begin
      bad++; $display("FAIL pace_words got=%0d want=3 ending %h with last", out_data.size(), bram_word(32'h208));
    end
  endtask

  task automatic test_loop();
    logic [31:0] exp_a;
    do_start(32'h300, 32'd8, 32'd4, 1'b1, 1'b0);
    for (int i = 0; i < 100 && en_cyc.size() < 5; i++) @(posedge clk);
    #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    wait_done(100);
    total++; if (en_cyc.size() != 5) begin bad++; $display("FAIL loop_issues got=%0d want=5", en_cyc.size()); end
    total++; if (out_data.size() != 5) begin bad++; $display("FAIL loop_words got=%0d want=5", out_data.size()); end
    for (int i = 0; i < out_data.size() && i < 5 && i < en_addr.size(); i++) begin
      exp_a = (i % 2 == 0) ? 32'h300 : 32'h304;
      total++;
      if (en_addr[i] !== exp_a || out_data[i] !== bram_word(exp_a) || out_last[i] !== (i % 2 == 1)) begin
        bad++; $display("FAIL loop_word%0d got=%h/%h/%b want=%h/%h/%b", i, en_addr[i], out_data[i], out_last[i], exp_a, bram_word(exp_a), i % 2 == 1);
      end
    end
    total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL loop_done got=%0d want=1", done_cyc.size()); end
  endtask

  task automatic test_backpressure();
    int issued_at_stall, popped_at_stall;
    logic [31:0] held;
    do_start(32'h400, 32'd64, 32'd1, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    strm_if.m_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    issued_at_stall = en_cyc.size(); popped_at_stall = out_data.size();
    held = strm_if.m_data;
    total++; if (issued_at_stall - popped_at_stall != FIFO_DEPTH) begin
      bad++; $display("FAIL bp_outstanding got=%0d want=%0d", issued_at_stall - popped_at_stall, FIFO_DEPTH);
    end
    total++; if (strm_if.m_valid !== 1'b1 || held !== bram_word(32'h400 + 32'(4*popped_at_stall))) begin
      bad++; $display("FAIL bp_head got=%b/%h want=1/%h", strm_if.m_valid, held, bram_word(32'h400 + 32'(4*popped_at_stall)));
    end
    @(posedge clk); #1;
    total++; if (strm_if.m_data !== held || en_cyc.size() != issued_at_stall) begin
      bad++; $display("FAIL bp_hold got=%h/%0d want=%h/%0d", strm_if.m_data, en_cyc.size(), held, issued_at_stall);
    end
    strm_if.m_ready = 1'b1;
    wait_done(200);
    total++; if (en_cyc.size() != 16 || out_data.size() != 16) begin
      bad++; $display("FAIL bp_counts got=%0d/%0d want=16/16", en_cyc.size(), out_data.size());
    end
    for (int i = 0; i < out_data.size() && i < 16; i++) begin
      total++;
      if (out_data[i] !== bram_word(32'h400 + 32'(4*i)) || out_last[i] !== (i == 15)) begin
        bad++; $display("FAIL bp_word%0d got=%h/%b want=%h/%b", i, out_data[i], out_last[i], bram_word(32'h400 + 32'(4*i)), i == 15);
      end
    end
  endtask

  task automatic test_zero_len();
    do_start(32'h800, 32'd3, 32'd1, 1'b0, 1'b0);
    #1;
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_done_c1 got=done%b busy%b want=10", done, busy); end
    repeat (6) @(posedge clk);
    total++; if (en_cyc.size() != 0 || done_cyc.size() != 1) begin
      bad++; $display("FAIL zero_activity got=en%0d done%0d want=en0 done1", en_cyc.size(), done_cyc.size());
    end
  endtask

  task automatic test_start_busy();
    do_start(32'h500, 32'd16, 32'd3, 1'b0, 1'b1);   // start+stop together: start wins
    @(posedge clk); #1;
    start_addr = 32'h900; rd_len = 32'd40; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(200);
    total++; if (en_cyc.size() != 4 || out_data.size() != 4 || done_cyc.size() != 1) begin
      bad++; $display("FAIL busy_start got=en%0d out%0d done%0d want=4/4/1", en_cyc.size(), out_data.size(), done_cyc.size());
    end
    for (int i = 0; i < en_addr.size() && i < 4; i++) begin
      total++;
      if (en_addr[i] !== 32'h500 + 32'(4*i)) begin
        bad++; $display("FAIL busy_start_addr%0d got=%h want=%h", i, en_addr[i], 32'h500 + 32'(4*i));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_start(32'h600, 32'd32, 32'd1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    total++; if (ram_en !== 1'b0 || ram_addr !== 32'h0) begin bad++; $display("FAIL rstmid_ram got=%b/%h want=0/0", ram_en, ram_addr); end
    total++; if (strm_if.m_valid !== 1'b0 || strm_if.m_last !== 1'b0) begin bad++; $display("FAIL rstmid_strm got=%b/%b want=0/0", strm_if.m_valid, strm_if.m_last); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rstmid_status got=%b/%b want=0/0", busy, done); end
    clear_logs();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (6) @(posedge clk);
    total++; if (done_cyc.size() != 0 || out_data.size() != 0) begin
      bad++; $display("FAIL rstmid_quiet got=done%0d out%0d want=0/0", done_cyc.size(), out_data.size());
    end
    do_start(32'h700, 32'd8, 32'd1, 1'b0, 1'b0);
    wait_done(100);
    total++; if (en_cyc.size() != 2 || en_addr[0] !== 32'h700 || en_cyc[0] != t0) begin
      bad++; $display("FAIL rstmid_restart got=n%0d first=%h want=n2 first=700", en_cyc.size(), (en_addr.size() > 0) ? en_addr[0] : 32'hX);
    end
    total++; if (out_data.size() != 2 || out_data[0] !== bram_word(32'h700) || out_data[1] !== bram_word(32'h704) || out_last[1] !== 1'b1) begin
      bad++; $display("FAIL rstmid_words got=n%0d want=2 words %h %h", out_data.size(), bram_word(32'h700), bram_word(32'h704));
    end
  endtask

  initial begin
    strm_if.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_oneshot();
    test_pacing();
    test_loop();
    test_backpressure();
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bram_stream_rd.md
# bram_stream_rd

Parametrised BRAM-to-stream reader; successor to the PL BRAM read block in the PS–PL BRAM exchange path. Once started, it reads a programmed window of a block RAM through the native BRAM port. Reads are paced by a programmable interval and the block supports one-shot or continuous-loop modes. Read data is delivered on a valid/ready stream with backpressure, an internal buffer that absorbs BRAM read latency, and busy/done status for the PS-side control registers.

## Interface
- DATA_W, 32, BRAM data width in bits; one of 32/64/128.
- ADDR_W, 32, BRAM byte-address width.
- RD_LAT, 1, BRAM read latency in cycles; 1 or 2.
- FIFO_DEPTH, 4, output buffer depth in words; power of two, ≥ RD_LAT+2.
- clk  in  1  system clock; also drives ram_clk.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a transfer when idle.
- stop  in  1  one-cycle pulse; ends a running transfer gracefully.
- mode  in  1  0 = one-shot, 1 = loop (wrap to start_addr after the last word).
- start_addr  in  ADDR_W  first byte address; must be aligned to DATA_W/8.
- rd_len  in  32  window length in bytes; truncated to a whole number of words.
- rd_freq  in  32  cycles between read issues; 0 is treated as 1.
- ram_clk  out  1  equals clk.
- ram_en  out  1  read strobe, one cycle per word.
- ram_addr  out  ADDR_W  byte address.
- ram_we  out  DATA_W/8  tied to 0.
- ram_wr_data  out  DATA_W  tied to 0.
- ram_rst  out  1  tied to 0.
- ram_rd_data  in  DATA_W  BRAM read data.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the last word of each pass through the window.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse on return to IDLE.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - On start, latch start_addr, mode, rd_len, rd_freq; compute nwords = rd_len >> log2(DATA_W/8).
  - If nwords == 0, pulse done and stay in IDLE. Otherwise go to RUN.
- RUN:
  - Issue a read (ram_en=1 for one cycle) when both conditions hold: the pace counter has expired, and credits > 0.
  - credits = free FIFO slots − reads in flight.
  - After each issue, ram_addr += DATA_W/8 and the word counter increments.
  - On the last word of a pass, tag the in-flight read with last. Then:
    - mode=1: reload ram_addr = start_addr and the word counter, and continue.
    - mode=0: go to DRAIN.
- stop in RUN: no further issues; go to DRAIN. Words already issued are still delivered. m_last appears only on true end-of-pass words.
- DRAIN: when in-flight == 0 and the FIFO is empty, go to IDLE and pulse done.
- start while busy is ignored. stop in IDLE is ignored. start and stop in the same cycle in IDLE: start wins, and the stop is ignored.
- Stream: m_data/m_last hold stable while m_valid && !m_ready. A word is transferred on m_valid && m_ready.
- Address arithmetic wraps modulo 2^ADDR_W. Word counter is 32 bits.

## Timing
- Reset values: all outputs 0, except ram_addr = 0. State = IDLE, FIFO empty, pace counter 0.
- start sampled at edge 0 → busy high in cycle 1; first ram_en in cycle 1.
- Data for a read issued in cycle t is sampled in cycle t+RD_LAT and written to the FIFO at the end of that cycle. m_valid is high from cycle t+RD_LAT+1.
- With m_ready held high, consecutive ram_en pulses are exactly max(rd_freq,1) cycles apart. rd_freq=1 gives one word per cycle sustained.
- Backpressure never overflows the FIFO; issuing resumes the cycle after credits > 0.
- done pulses the cycle after the final handshake in DRAIN (or the cycle after start when nwords == 0). busy falls in the same cycle done is high.
- Async reset mid-transfer clears everything immediately. In-flight BRAM data is discarded, and no done pulse is generated.

## Structure
- Package bram_rd_pkg: state enum (IDLE/RUN/DRAIN), mode encoding constants, and a clog2 helper for the byte-lane shift.
- Sub-module sync_fifo (DATA_W+1 wide, FIFO_DEPTH deep, registered output), used for the data+last buffer.
- Top: control FSM, pace counter, address/word counters, in-flight tracking (an RD_LAT-deep valid/last shift pipe).

## Test plan
- One-shot, DATA_W=32, start_addr=0x100, rd_len=16, rd_freq=1, m_ready=1 → addresses 0x100, 0x104, 0x108, 0x10C on consecutive cycles; 4 words out; m_last on the 4th; single done pulse.
- Pacing: rd_freq=5, rd_len=12 → ram_en pulses exactly 5 cycles apart; 3 words out.
- Loop, rd_len=8, stop asserted after 5 issues → address sequence base, +4, base, +4, base; m_last on words 2 and 4; all 5 words delivered; then done.
- Backpressure: m_ready low for 20 cycles mid-transfer, RD_LAT=2 → no word lost or duplicated; ram_en stops once FIFO_DEPTH words are buffered or in flight.
- Edge cases: rd_len=3 (zero words) → done the cycle after start, no ram_en. start pulsed while busy → ignored.
- Reset: rst_n low during RUN with 2 reads in flight → all outputs 0 immediately; a fresh start afterwards begins cleanly at start_addr.
